// File: rtl/sqrt_scheduler_if.sv
// Request/grant and result bundle between two sqrt requesters and the scheduler.
// master = requester side, slave = scheduler side.
interface sqrt_scheduler_if;
    logic        req0;
    logic [7:0]  in0;
    logic        req1;
    logic [7:0]  in1;
    logic        gnt0;
    logic        gnt1;
    logic [15:0] out;
    logic        out_valid;
    logic        out_id;
    logic        busy;

    modport master (
        output req0, in0, req1, in1,
        input  gnt0, gnt1, out, out_valid, out_id, busy
    );

    modport slave (
        input  req0, in0, req1, in1,
        output gnt0, gnt1, out, out_valid, out_id, busy
    );
endinterface

// File: rtl/sqrt_scheduler.sv
// Two-requester arbiter feeding a 12-cycle restoring Q8.8 sqrt; SQRT_SCHED_RR_EN selects round-robin arbitration.
// Grant (combinational, IDLE only) to out_valid is 13 cycles; requests raised while busy wait, held, until IDLE.
module sqrt_scheduler (
    input  logic            clk,
    input  logic            rst_n,
    sqrt_scheduler_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  opnd_q, opnd_d;
    logic [13:0] rem_q, rem_d;
    logic [11:0] root_q, root_d;
    logic        id_q, id_d;
    logic [15:0] out_q, out_d;
    logic        out_id_q, out_id_d;

    logic        idle;
    logic        pick0;
    logic        gnt0, gnt1;
    logic [15:0] rem_sh;
    logic [13:0] trial;
    logic        ge;
    logic [13:0] rem_nx;
    logic [11:0] root_nx;

    assign idle = (state_q == ST_IDLE);

`ifdef SQRT_SCHED_RR_EN
    // ptr_q = index served last; on contention the other requester wins.
    logic ptr_q, ptr_d;

    assign pick0 = bus.req0 & (~bus.req1 | ptr_q);
    assign ptr_d = gnt0 ? 1'b0 : (gnt1 ? 1'b1 : ptr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b1;
        else        ptr_q <= ptr_d;
    end
`else
    assign pick0 = bus.req0;
`endif

    // Gated by rst_n so no grant leaks out while reset is held.
    assign gnt0 = rst_n & idle & pick0;
    assign gnt1 = rst_n & idle & bus.req1 & ~pick0;

    // One restoring step; the 14-bit difference is exact whenever ge is set.
    assign rem_sh  = {rem_q, opnd_q[7:6]};
    assign trial   = {root_q, 2'b01};
    assign ge      = (rem_sh >= {2'b00, trial});
    assign rem_nx  = ge ? (rem_sh[13:0] - trial) : rem_sh[13:0];
    assign root_nx = {root_q[10:0], ge};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        rem_d    = rem_q;
        root_d   = root_q;
        id_d     = id_q;
        out_d    = out_q;
        out_id_d = out_id_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt0 || gnt1) begin
                    state_d = ST_CALC;
                    cnt_d   = 4'd0;
                    opnd_d  = gnt0 ? bus.in0 : bus.in1;
                    id_d    = gnt1;
                    rem_d   = 14'd0;
                    root_d  = 12'd0;
                end
            end
            ST_CALC: begin
                rem_d  = rem_nx;
                root_d = root_nx;
                opnd_d = {opnd_q[5:0], 2'b00};
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd11) begin
                    state_d  = ST_DONE;
                    out_d    = {4'h0, root_nx};
                    out_id_d = id_q;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            opnd_q   <= 8'd0;
            rem_q    <= 14'd0;
            root_q   <= 12'd0;
            id_q     <= 1'b0;
            out_q    <= 16'h0000;
            out_id_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            rem_q    <= rem_d;
            root_q   <= root_d;
            id_q     <= id_d;
            out_q    <= out_d;
            out_id_q <= out_id_d;
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.out       = out_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = ~idle;
endmodule

// File: tb/tb_sqrt_scheduler.sv
// Directed bench for sqrt_scheduler: reset, single ops, arbitration, late request, mid-op reset.
module tb_sqrt_scheduler;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    sqrt_scheduler_if ifc();

    sqrt_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Issue one request, wait for its grant and result; outputs are raw observations.
    task automatic do_op(input bit id, input logic [7:0] opnd, output logic [15:0] res,
                         output logic rid, output int lat, output bit ok);
        int  t0;
        bit  got;
        bit  vld;
        t0 = 0; got = 0; vld = 0; res = 16'hxxxx; rid = 1'bx; lat = -1;
        @(posedge clk); #1;
        if (id) begin ifc.req1 = 1'b1; ifc.in1 = opnd; end
        else    begin ifc.req0 = 1'b1; ifc.in0 = opnd; end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (id ? ifc.gnt1 : ifc.gnt0) begin got = 1; t0 = cyc; end
        end
        @(posedge clk); #1;
        ifc.req0 = 1'b0;
        ifc.req1 = 1'b0;
        for (int i = 0; i < 20 && got && !vld; i++) begin
            @(negedge clk);
            if (ifc.out_valid) begin
                vld = 1; res = ifc.out; rid = ifc.out_id; lat = cyc - t0;
            end
        end
        ok = got && vld;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.req0 = 1'b1; ifc.in0 = 8'd144;
        ifc.req1 = 1'b1; ifc.in1 = 8'd9;
        repeat (2) @(negedge clk);
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", ifc.busy); end
        checks++; if (ifc.out !== 16'h0000) begin errors++; $display("FAIL rst_out: got %h want 0000", ifc.out); end
        checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", ifc.out_valid); end
        checks++; if (ifc.out_id !== 1'b0) begin errors++; $display("FAIL rst_out_id: got %b want 0", ifc.out_id); end
        checks++; if (ifc.gnt0 !== 1'b0 || ifc.gnt1 !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b%b want 00", ifc.gnt0, ifc.gnt1); end
        ifc.req0 = 1'b0; ifc.req1 = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] res; logic rid; int lat; bit ok;
        do_op(1'b0, 8'd144, res, rid, lat, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done: op did not complete"); end
        checks++; if (lat != 13) begin errors++; $display("FAIL basic_latency: got %0d want 13", lat); end
        checks++; if (res !== 16'h0C00) begin errors++; $display("FAIL basic_out: got %h want 0c00", res); end
        checks++; if (rid !== 1'b0) begin errors++; $display("FAIL basic_id: got %b want 0", rid); end
        @(negedge clk);
        checks++; if (ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0) begin errors++; $display("FAIL basic_after: valid=%b busy=%b want 0 0", ifc.out_valid, ifc.busy); end
        checks++; if (ifc.out !== 16'h0C00) begin errors++; $display("FAIL basic_hold: got %h want 0c00", ifc.out); end
    endtask

    task automatic test_values();
        logic [7:0]  ops [4];
        logic [15:0] exps[4];
        logic [15:0] res; logic rid; int lat; bit ok;
        ops  = '{8'd2, 8'd255, 8'd200, 8'd0};
        exps = '{16'h016A, 16'h0FF7, 16'h0E24, 16'h0000};
        for (int k = 0; k < 4; k++) begin
            do_op(1'b1, ops[k], res, rid, lat, ok);
            checks++; if (!ok || lat != 13) begin errors++; $display("FAIL val_latency[%0d]: ok=%b lat=%0d want 13", k, ok, lat); end
            checks++; if (res !== exps[k]) begin errors++; $display("FAIL val_out[%0d]: in=%0d got %h want %h", k, ops[k], res, exps[k]); end
            checks++; if (rid !== 1'b1) begin errors++; $display("FAIL val_id[%0d]: got %b want 1", k, rid); end
        end
    endtask

    task automatic test_both();
        int g_cyc[8]; bit g_id[8]; int ng; int both; int r0;
        ng = 0; both = 0;
        @(posedge clk); #1 rst_n = 1'b0;
        ifc.req0 = 1'b1; ifc.in0 = 8'd4;
        ifc.req1 = 1'b1; ifc.in1 = 8'd9;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        r0 = cyc;
        for (int i = 0; i < 41; i++) begin
            @(negedge clk);
            if (ifc.gnt0 && ifc.gnt1) both++;
            if ((ifc.gnt0 || ifc.gnt1) && ng < 8) begin g_cyc[ng] = cyc - r0; g_id[ng] = ifc.gnt1; ng++; end
        end
        ifc.req0 = 1'b0; ifc.req1 = 1'b0;
        checks++; if (both != 0) begin errors++; $display("FAIL both_gnt_overlap: got %0d cycles want 0", both); end
        checks++; if (ng != 3) begin errors++; $display("FAIL both_count: got %0d grants want 3", ng); end
        checks++; if (g_cyc[0] != 0 || g_cyc[1] != 14 || g_cyc[2] != 28) begin errors++; $display("FAIL both_spacing: got %0d %0d %0d want 0 14 28", g_cyc[0], g_cyc[1], g_cyc[2]); end
`ifdef SQRT_SCHED_RR_EN
        checks++; if (g_id[0] !== 1'b0 || g_id[1] !== 1'b1 || g_id[2] !== 1'b0) begin errors++; $display("FAIL both_order: got %b%b%b want 010", g_id[0], g_id[1], g_id[2]); end
`else
        checks++; if (g_id[0] !== 1'b0 || g_id[1] !== 1'b0 || g_id[2] !== 1'b0) begin errors++; $display("FAIL both_order: got %b%b%b want 000", g_id[0], g_id[1], g_id[2]); end
`endif
        for (int i = 0; i < 20 && ifc.busy; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_late();
        int t0, tg1, nv; bit got0;
        logic [15:0] vout[2]; logic vid[2]; int vc[2];
        t0 = -100; tg1 = -1; nv = 0; got0 = 0;
        vc = '{-1, -1}; vid = '{1'bx, 1'bx}; vout = '{16'hxxxx, 16'hxxxx};
        @(posedge clk); #1 ifc.req0 = 1'b1; ifc.in0 = 8'd16;
        for (int i = 0; i < 20 && !got0; i++) begin
            @(negedge clk);
            if (ifc.gnt0) begin got0 = 1; t0 = cyc; end
        end
        checks++; if (!got0) begin errors++; $display("FAIL late_gnt0: no grant"); end
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            ifc.req0 = 1'b0;
            if (cyc == t0 + 3) begin ifc.req1 = 1'b1; ifc.in1 = 8'd1; end
            if (tg1 >= 0) ifc.req1 = 1'b0;
            @(negedge clk);
            if (ifc.gnt1 && tg1 < 0) tg1 = cyc;
            if (ifc.out_valid && nv < 2) begin vout[nv] = ifc.out; vid[nv] = ifc.out_id; vc[nv] = cyc; nv++; end
        end
        ifc.req1 = 1'b0;
        checks++; if (tg1 != t0 + 14) begin errors++; $display("FAIL late_gnt1_cycle: got %0d want %0d", tg1 - t0, 14); end
        checks++; if (nv != 2) begin errors++; $display("FAIL late_results: got %0d want 2", nv); end
        checks++; if (vc[0] != t0 + 13 || vid[0] !== 1'b0 || vout[0] !== 16'h0400) begin errors++; $display("FAIL late_first: at +%0d id=%b out=%h want +13 0 0400", vc[0] - t0, vid[0], vout[0]); end
        checks++; if (vc[1] != t0 + 27 || vid[1] !== 1'b1 || vout[1] !== 16'h0100) begin errors++; $display("FAIL late_second: at +%0d id=%b out=%h want +27 1 0100", vc[1] - t0, vid[1], vout[1]); end
    endtask

    task automatic test_abort();
        int t0, nvalid; bit got;
        logic [15:0] res; logic rid; int lat; bit ok;
        t0 = -100; nvalid = 0; got = 0;
        @(posedge clk); #1 ifc.req0 = 1'b1; ifc.in0 = 8'd100;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ifc.gnt0) begin got = 1; t0 = cyc; end
        end
        for (int i = 0; i < 10 && cyc != t0 + 6; i++) begin
            @(posedge clk); #1 ifc.req0 = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", ifc.busy); end
        checks++; if (ifc.out !== 16'h0000) begin errors++; $display("FAIL abort_out: got %h want 0000", ifc.out); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (ifc.out_valid) nvalid++;
        end
        checks++; if (nvalid != 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses want 0", nvalid); end
        do_op(1'b1, 8'd49, res, rid, lat, ok);
        checks++; if (!ok || lat != 13 || res !== 16'h0700 || rid !== 1'b1) begin errors++; $display("FAIL abort_recover: ok=%b lat=%0d out=%h id=%b want 1 13 0700 1", ok, lat, res, rid); end
    endtask

    initial begin
        ifc.req0 = 1'b0; ifc.in0 = 8'd0;
        ifc.req1 = 1'b0; ifc.in1 = 8'd0;
        test_reset();
        test_basic();
        test_values();
        test_both();
        test_late();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
